// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled pipelined RAM.
package ram_pkg;

  typedef enum logic {
    RAM_IDLE = 1'b0,
    RAM_INIT = 1'b1
  } ram_state_e;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned MAX_D_W  = 256;
  localparam int unsigned MAX_BE_W = MAX_D_W / BYTE_W;

  // Replace each enabled byte lane of old_w with the matching lane of new_w.
  function automatic logic [MAX_D_W-1:0] be_merge(
    input logic [MAX_D_W-1:0]  old_w,
    input logic [MAX_D_W-1:0]  new_w,
    input logic [MAX_BE_W-1:0] be
  );
    logic [MAX_D_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(MAX_BE_W); i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_be_pipe_if.sv
// Request/response bundle between a RAM client (master) and ram_be_pipe (slave).
interface ram_be_pipe_if
  import ram_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 4
);

  logic                       wr_en;
  logic [A_WIDTH-1:0]         wr_addr;
  logic [D_WIDTH-1:0]         wr_data;
  logic [D_WIDTH/BYTE_W-1:0]  wr_be;
  logic                       rd_en;
  logic [A_WIDTH-1:0]         rd_addr;
  logic [D_WIDTH-1:0]         rd_data;
  logic                       rd_valid;
  logic                       rd_err;
  logic                       wr_err;
  logic                       init_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_err, wr_err, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, rd_err, wr_err, init_busy
  );

endinterface

// File: rtl/ram_init_seq.sv
// Post-reset initialisation sweep: walks addresses 0..A_MAX once, one per cycle.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int unsigned A_WIDTH       = 4,
  parameter int unsigned A_MAX         = 11,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               init_we,
  output logic [A_WIDTH-1:0] init_addr,
  output logic               init_busy
);

  ram_state_e         state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_ON_RESET ? RAM_INIT : RAM_IDLE;
      cnt_q   <= '0;
      busy_q  <= INIT_ON_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Busy drops together with the write of the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      RAM_INIT: begin
        if (cnt_q == A_WIDTH'(A_MAX)) begin
          state_d = RAM_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + A_WIDTH'(1);
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign init_we   = busy_q;
  assign init_addr = cnt_q;
  assign init_busy = busy_q;

endmodule

// File: rtl/ram_be_pipe.sv
// Dual-port (1W/1R) byte-enabled RAM with 1- or 2-cycle read pipeline,
// configurable collision policy, range errors and optional init sweep.
module ram_be_pipe
  import ram_pkg::*;
#(
  parameter int unsigned        D_WIDTH       = 32,
  parameter int unsigned        A_WIDTH       = 4,
  parameter int unsigned        A_MAX         = 11,
  parameter int unsigned        READ_LATENCY  = 1,
  parameter bit                 WRITE_FIRST   = 1'b1,
  parameter bit                 INIT_ON_RESET = 1'b1,
  parameter logic [D_WIDTH-1:0] INIT_VALUE    = '0
) (
  input logic          clk,
  input logic          rst,
  ram_be_pipe_if.slave bus
);

  if ((D_WIDTH % BYTE_W) != 0 || D_WIDTH > MAX_D_W) begin : g_bad_dw
    $fatal(1, "ram_be_pipe: D_WIDTH must be a multiple of 8 and <= MAX_D_W");
  end
  if (A_MAX > (2 ** A_WIDTH) - 1) begin : g_bad_amax
    $fatal(1, "ram_be_pipe: A_MAX exceeds the address space");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "ram_be_pipe: READ_LATENCY must be 1 or 2");
  end

  logic [D_WIDTH-1:0] mem [0:A_MAX];

  logic               init_we;
  logic [A_WIDTH-1:0] init_addr;
  logic               init_busy;

  ram_init_seq #(
    .A_WIDTH      (A_WIDTH),
    .A_MAX        (A_MAX),
    .INIT_ON_RESET(INIT_ON_RESET)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_busy(init_busy)
  );

  logic               wr_req_c, wr_oor_c, wr_ok_c;
  logic               rd_req_c, rd_oor_c;
  logic [D_WIDTH-1:0] wr_merged_c, rd_word_c;

  // Request qualification, lane merge and collision bypass.
  always_comb begin
    wr_req_c    = bus.wr_en & ~init_busy & ~rst;
    wr_oor_c    = bus.wr_addr > A_WIDTH'(A_MAX);
    wr_ok_c     = wr_req_c & ~wr_oor_c;
    rd_req_c    = bus.rd_en & ~init_busy & ~rst;
    rd_oor_c    = bus.rd_addr > A_WIDTH'(A_MAX);
    wr_merged_c = D_WIDTH'(be_merge(MAX_D_W'(mem[bus.wr_addr]),
                                    MAX_D_W'(bus.wr_data),
                                    MAX_BE_W'(bus.wr_be)));
    rd_word_c   = '0;
    if (!rd_oor_c) begin
      if (WRITE_FIRST && wr_ok_c && (bus.wr_addr == bus.rd_addr)) rd_word_c = wr_merged_c;
      else rd_word_c = mem[bus.rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= INIT_VALUE;
    else if (wr_ok_c) mem[bus.wr_addr] <= wr_merged_c;
  end

  logic               p_valid, p_err;
  logic [D_WIDTH-1:0] p_data;
  logic               fin_valid_c, fin_err_c;
  logic [D_WIDTH-1:0] fin_data_c;
  logic               rd_valid_q, rd_err_q, wr_err_q;
  logic [D_WIDTH-1:0] rd_data_q;

  // Final read stage comes straight from the array (latency 1) or from p_* (latency 2).
  always_comb begin
    fin_valid_c = (READ_LATENCY == 1) ? rd_req_c  : p_valid;
    fin_err_c   = (READ_LATENCY == 1) ? rd_oor_c  : p_err;
    fin_data_c  = (READ_LATENCY == 1) ? rd_word_c : p_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid    <= 1'b0;
      p_err      <= 1'b0;
      p_data     <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      p_valid    <= rd_req_c;
      p_err      <= rd_oor_c;
      p_data     <= rd_word_c;
      rd_valid_q <= fin_valid_c;
      rd_err_q   <= fin_valid_c & fin_err_c;
      if (fin_valid_c) rd_data_q <= fin_data_c;
      wr_err_q   <= wr_req_c & wr_oor_c;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_ram_be_pipe.sv
// Two ram_be_pipe configurations driven in lockstep and checked against an array model.
module tb_ram_be_pipe;

  localparam int unsigned AMX = 11;
  localparam int unsigned NW  = AMX + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_be_pipe_if #(.D_WIDTH(32), .A_WIDTH(4)) bus_a ();
  ram_be_pipe_if #(.D_WIDTH(32), .A_WIDTH(4)) bus_b ();

  // a: latency 1, write-first, init 0xDEADBEEF.  b: latency 2, read-first, init 0.
  ram_be_pipe #(
    .D_WIDTH(32), .A_WIDTH(4), .A_MAX(AMX), .READ_LATENCY(1),
    .WRITE_FIRST(1'b1), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'hDEADBEEF)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  ram_be_pipe #(
    .D_WIDTH(32), .A_WIDTH(4), .A_MAX(AMX), .READ_LATENCY(2),
    .WRITE_FIRST(1'b0), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h0)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] m_mem [2][NW];
  int          busy_left [2];
  logic        sv_v [2][4];
  logic        sv_e [2][4];
  logic [31:0] sv_d [2][4];
  logic        x_v [2];
  logic        x_e [2];
  logic        x_we [2];
  logic [31:0] x_d [2];

  function automatic int lat(input int m);
    return (m == 0) ? 1 : 2;
  endfunction

  function automatic bit wfirst(input int m);
    return m == 0;
  endfunction

  function automatic logic [31:0] initv(input int m);
    return (m == 0) ? 32'hDEADBEEF : 32'h0;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reads are scheduled into a slot keyed by the edge at which they must surface.
  task automatic model_edge(input int m, input logic r, input logic we, input logic [3:0] wa,
                            input logic [31:0] wd, input logic [3:0] be, input logic re,
                            input logic [3:0] ra);
    int          s;
    logic [31:0] rdw;
    if (r) begin
      for (int k = 0; k < 4; k++) sv_v[m][k] = 1'b0;
      for (int a = 0; a < int'(NW); a++) m_mem[m][a] = initv(m);
      busy_left[m] = NW;
      x_v[m] = 1'b0; x_e[m] = 1'b0; x_d[m] = 32'h0; x_we[m] = 1'b0;
    end else begin
      x_we[m] = 1'b0;
      if (busy_left[m] > 0) begin
        busy_left[m]--;
      end else begin
        if (re) begin
          s = (cyc + lat(m) - 1) % 4;
          if (int'(ra) > int'(AMX)) begin
            sv_d[m][s] = 32'h0; sv_e[m][s] = 1'b1;
          end else begin
            rdw = m_mem[m][ra];
            if (wfirst(m) && we && wa == ra) rdw = lane_merge(rdw, wd, be);
            sv_d[m][s] = rdw; sv_e[m][s] = 1'b0;
          end
          sv_v[m][s] = 1'b1;
        end
        if (we) begin
          if (int'(wa) > int'(AMX)) x_we[m] = 1'b1;
          else m_mem[m][wa] = lane_merge(m_mem[m][wa], wd, be);
        end
      end
      s = cyc % 4;
      x_v[m] = sv_v[m][s];
      x_e[m] = sv_v[m][s] & sv_e[m][s];
      if (sv_v[m][s]) x_d[m] = sv_d[m][s];
      sv_v[m][s] = 1'b0;
    end
  endtask

  task automatic check_m(input int m);
    logic        v, e, we, b;
    logic [31:0] d;
    string       nm;
    if (m == 0) begin
      v = bus_a.rd_valid; e = bus_a.rd_err; we = bus_a.wr_err; b = bus_a.init_busy;
      d = bus_a.rd_data; nm = "a";
    end else begin
      v = bus_b.rd_valid; e = bus_b.rd_err; we = bus_b.wr_err; b = bus_b.init_busy;
      d = bus_b.rd_data; nm = "b";
    end
    chk({nm, ".init_busy"}, 32'(b), 32'(busy_left[m] > 0));
    chk({nm, ".rd_valid"}, 32'(v), 32'(x_v[m]));
    chk({nm, ".rd_err"}, 32'(e), 32'(x_e[m]));
    chk({nm, ".wr_err"}, 32'(we), 32'(x_we[m]));
    chk({nm, ".rd_data"}, d, x_d[m]);
  endtask

  task automatic step(input logic r, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic re, input logic [3:0] ra);
    rst = r;
    bus_a.wr_en = we; bus_a.wr_addr = wa; bus_a.wr_data = wd; bus_a.wr_be = be;
    bus_a.rd_en = re; bus_a.rd_addr = ra;
    bus_b.wr_en = we; bus_b.wr_addr = wa; bus_b.wr_data = wd; bus_b.wr_be = be;
    bus_b.rd_en = re; bus_b.rd_addr = ra;
    @(posedge clk);
    model_edge(0, r, we, wa, wd, be, re, ra);
    model_edge(1, r, we, wa, wd, be, re, ra);
    cyc++;
    @(negedge clk);
    check_m(0);
    check_m(1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b0, 1'b1, a, d, be, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, a);
  endtask

  task automatic random_phase(input int n);
    logic [3:0] wa, ra;
    repeat (n) begin
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      step(1'b0, 1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ra);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    chk("a.reset_busy", 32'(bus_a.init_busy), 32'd1);
    chk("a.reset_data", bus_a.rd_data, 32'h0);

    // Requests during the sweep are dropped; 12 cycles of busy in total.
    step(1'b0, 1'b1, 4'd2, 32'h12345678, 4'hF, 1'b1, 4'd2);
    idle(10);
    chk("a.busy_last", 32'(bus_a.init_busy), 32'd1);
    idle(1);
    chk("a.busy_done", 32'(bus_a.init_busy), 32'd0);

    rd(4'd11);
    chk("a.init_word", bus_a.rd_data, 32'hDEADBEEF);
    chk("a.init_valid", 32'(bus_a.rd_valid), 32'd1);
    rd(4'd2);
    chk("a.busy_wr_ignored", bus_a.rd_data, 32'hDEADBEEF);
    idle(1);

    wr(4'd3, 32'h11223344, 4'hF);
    wr(4'd3, 32'hAABBCCDD, 4'h5);
    rd(4'd3);
    chk("a.lane_merge", bus_a.rd_data, 32'h11BB33DD);
    idle(1);
    chk("b.lane_merge", bus_b.rd_data, 32'h11BB33DD);

    wr(4'd5, 32'h0, 4'hF);
    step(1'b0, 1'b1, 4'd5, 32'hCAFEF00D, 4'hF, 1'b1, 4'd5);
    chk("a.collide_wf", bus_a.rd_data, 32'hCAFEF00D);
    rd(4'd5);
    chk("b.collide_rf", bus_b.rd_data, 32'h0);
    idle(1);
    chk("b.after_collide", bus_b.rd_data, 32'hCAFEF00D);

    wr(4'd13, 32'hFFFFFFFF, 4'hF);
    chk("a.wr_err_pulse", 32'(bus_a.wr_err), 32'd1);
    rd(4'd14);
    chk("a.wr_err_clear", 32'(bus_a.wr_err), 32'd0);
    chk("a.rd_err", 32'(bus_a.rd_err), 32'd1);
    chk("a.rd_err_data", bus_a.rd_data, 32'h0);
    idle(1);
    chk("b.rd_err", 32'(bus_b.rd_err), 32'd1);

    rd(4'd0); rd(4'd1); rd(4'd2);
    idle(2);

    wr(4'd4, 32'h55555555, 4'h0);
    rd(4'd4);
    chk("a.be_zero", bus_a.rd_data, 32'hDEADBEEF);
    idle(1);

    random_phase(400);

    // Reset in the middle of a sweep restarts it from address 0.
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    idle(5);
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd2, 32'h12345678, 4'hF, 1'b0, 4'd0);
    idle(10);
    chk("a.resweep_busy", 32'(bus_a.init_busy), 32'd1);
    idle(1);
    chk("a.resweep_done", 32'(bus_a.init_busy), 32'd0);
    rd(4'd2);
    chk("a.resweep_word", bus_a.rd_data, 32'hDEADBEEF);

    random_phase(300);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
